// File: rtl/m1_pkg.sv
// Shared definitions for the multi-key press counter.
//   key_level_e : active-low key levels (KEY_DOWN = 0, KEY_UP = 1)
//   CNT_RST_BIT / LEDS_RST_BIT : fill bit for counter / LED reset values
//   clog2()     : ceiling log2, used to size selects and debounce counters
package m1_pkg;

  typedef enum logic {
    KEY_DOWN = 1'b0,
    KEY_UP   = 1'b1
  } key_level_e;

  localparam logic CNT_RST_BIT  = 1'b0;
  localparam logic LEDS_RST_BIT = 1'b0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/m1_debounce.sv
// One key channel: two-flop synchroniser, counting debounce filter and
// falling-edge (press) detector.
//   clk, rst : system clock, asynchronous active-high reset
//   key_raw  : raw asynchronous key, active-low
//   press    : one-cycle pulse when the filtered level goes up -> down;
//              decoded from flops only, so it has no path from key_raw
module m1_debounce
  import m1_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned     DCW   = (clog2(DEBOUNCE) > 0) ? clog2(DEBOUNCE) : 1;
  localparam logic [DCW-1:0]  DLAST = DCW'(DEBOUNCE - 1);

  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           db_q, db_d;
  logic           db_prev_q, db_prev_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;

  // Any cycle where s2 agrees with db restarts the count, so a glitch
  // must persist for DEBOUNCE consecutive cycles to change db.
  always_comb begin
    s1_d      = key_raw;
    s2_d      = s1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    dcnt_d    = '0;
    if (s2_q != db_q) begin
      if (dcnt_q == DLAST) begin
        db_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= KEY_UP;
      s2_q      <= KEY_UP;
      db_q      <= KEY_UP;
      db_prev_q <= KEY_UP;
      dcnt_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign press = (db_prev_q == KEY_UP) && (db_q == KEY_DOWN);

endmodule

// File: rtl/m1_keycnt.sv
// Debounced press counter for NKEYS active-low keys, one WIDTH-bit counter
// per key, wrapping or saturating, with sticky overflow flags.
//   clk, rst : system clock, asynchronous active-high reset
//   key      : raw keys, active-low
//   clr      : synchronous clear of all counters and ovf flags
//   sel      : channel shown on leds (out-of-range shows 0)
//   leds     : registered copy of the selected counter
//   press    : registered one-cycle pulse per accepted press
//   ovf      : sticky per-channel wrap/saturation flag
module m1_keycnt
  import m1_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NKEYS    = 2,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned SELW     = (clog2(NKEYS) > 1) ? clog2(NKEYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key,
  input  logic             clr,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] leds,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_RST  = {WIDTH{CNT_RST_BIT}};
  localparam logic [WIDTH-1:0] LEDS_RST = {WIDTH{LEDS_RST_BIT}};

  logic [NKEYS-1:0] fall;

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    m1_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk    (clk),
      .rst    (rst),
      .key_raw(key[g]),
      .press  (fall[g])
    );
  end

  logic [WIDTH-1:0] cnt_q [NKEYS];
  logic [WIDTH-1:0] cnt_d [NKEYS];
  logic [NKEYS-1:0] ovf_q, ovf_d;
  logic [NKEYS-1:0] press_q, press_d;
  logic [WIDTH-1:0] leds_q, leds_d;

  // Counters update on the same edge the press pulse is registered, so
  // both use the unregistered edge from the debouncer.
  always_comb begin
    press_d = fall;
    ovf_d   = ovf_q;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (fall[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          if (SATURATE == 0) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
    // clr overrides any same-cycle update; press_d is left untouched
    if (clr) begin
      ovf_d = '0;
      for (int unsigned i = 0; i < NKEYS; i++) cnt_d[i] = CNT_RST;
    end
  end

  always_comb begin
    leds_d = LEDS_RST;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (sel == SELW'(i)) leds_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NKEYS; i++) cnt_q[i] <= CNT_RST;
      ovf_q   <= '0;
      press_q <= '0;
      leds_q  <= LEDS_RST;
    end else begin
      for (int unsigned i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
      ovf_q   <= ovf_d;
      press_q <= press_d;
      leds_q  <= leds_d;
    end
  end

  assign leds  = leds_q;
  assign press = press_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_m1_keycnt.sv
module tb_m1_keycnt;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] key = 2'b11;
  logic       clr = 1'b0;
  logic [0:0] sel = 1'b0;
  logic [7:0] leds, leds_s, leds3;
  logic [1:0] press, press_s, ovf, ovf_s;
  logic [2:0] key3, press3, ovf3;
  logic [1:0] sel3 = 2'd0;

  int n_total = 0;
  int n_pass  = 0;
  int pc0 = 0;
  int pc1 = 0;

  assign key3 = {1'b1, key};

  always #5 clk = ~clk;

  m1_keycnt #(.WIDTH(8), .NKEYS(2), .DEBOUNCE(4), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .key(key), .clr(clr), .sel(sel),
    .leds(leds), .press(press), .ovf(ovf)
  );

  m1_keycnt #(.WIDTH(8), .NKEYS(2), .DEBOUNCE(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .key(key), .clr(clr), .sel(sel),
    .leds(leds_s), .press(press_s), .ovf(ovf_s)
  );

  m1_keycnt #(.WIDTH(8), .NKEYS(3), .DEBOUNCE(4), .SATURATE(0)) dut3 (
    .clk(clk), .rst(rst), .key(key3), .clr(clr), .sel(sel3),
    .leds(leds3), .press(press3), .ovf(ovf3)
  );

  // Pulses are one cycle wide, so sampling on the falling edge counts each once.
  always @(negedge clk) begin
    if (press[0] === 1'b1) pc0++;
    if (press[1] === 1'b1) pc1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key0();
    key[0] = 1'b0;
    repeat (6) tick();
    key[0] = 1'b1;
    repeat (6) tick();
  endtask

  int base;

  initial begin
    // Asynchronous reset with random keys, before any clock edge
    key = 2'($urandom);
    #1 rst = 1'b1;
    #1;
    check("rst_leds",  leds,  0);
    check("rst_press", press, 0);
    check("rst_ovf",   ovf,   0);
    key = 2'b11;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Clean press on key[0]: press at E6, leds at E7, release silent
    sel = 1'b0;
    key[0] = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (e == 5) check("clean_press_E5", press[0], 0);
      if (e == 6) begin
        check("clean_press_E6", press[0], 1);
        check("clean_leds_E6", leds, 0);
      end
      if (e == 7) begin
        check("clean_press_E7", press[0], 0);
        check("clean_leds_E7", leds, 1);
      end
    end
    key[0] = 1'b1;
    repeat (12) tick();
    check("clean_one_pulse", pc0, 1);

    // Bounce on key[1]: 3 low / 1 high x5, then held low
    sel = 1'b1;
    repeat (5) begin
      key[1] = 1'b0;
      repeat (3) tick();
      key[1] = 1'b1;
      tick();
    end
    key[1] = 1'b0;
    repeat (10) tick();
    key[1] = 1'b1;
    repeat (10) tick();
    check("bounce_pulses", pc1, 1);
    check("bounce_cnt1", leds, 1);

    // 3-cycle low glitch on key[0] is rejected
    key[0] = 1'b0;
    repeat (3) tick();
    key[0] = 1'b1;
    repeat (10) tick();
    check("glitch_no_press", pc0, 1);

    // Simultaneous presses on both channels
    key = 2'b00;
    repeat (8) tick();
    key = 2'b11;
    repeat (10) tick();
    check("simul_pc0", pc0, 2);
    check("simul_pc1", pc1, 2);
    sel = 1'b0;
    tick();
    check("simul_cnt0", leds, 2);
    sel = 1'b1;
    tick();
    check("simul_cnt1", leds, 2);

    // clr in the same cycle as a press: clear wins, pulse still emitted
    key[0] = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) clr = 1'b1;
      if (e == 6) begin
        clr = 1'b0;
        check("clr_press_seen", press[0], 1);
      end
    end
    key[0] = 1'b1;
    tick();
    check("clr_cnt1", leds, 0);
    check("clr_ovf", ovf, 0);
    sel = 1'b0;
    tick();
    check("clr_cnt0", leds, 0);
    repeat (10) tick();
    check("clr_pc0", pc0, 3);

    // Wrap (dut) and saturate (dut_sat) on key[0]
    repeat (255) press_key0();
    check("wrap_255_leds", leds, 255);
    check("wrap_255_ovf", ovf, 0);
    check("sat_255_leds", leds_s, 255);
    check("sat_255_ovf", ovf_s, 0);
    press_key0();
    check("wrap_256_leds", leds, 0);
    check("wrap_256_ovf", ovf, 2'b01);
    check("sat_256_leds", leds_s, 255);
    check("sat_256_ovf", ovf_s, 2'b01);
    press_key0();
    check("wrap_257_leds", leds, 1);
    check("wrap_257_ovf_sticky", ovf, 2'b01);
    check("sat_257_leds", leds_s, 255);

    // Key held low through a mid-cycle reset
    key[0] = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_leds", leds, 0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_press", press, 0);
    repeat (3) tick();
    rst = 1'b0;
    base = pc0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 5) check("held_press_E5", press[0], 0);
      if (e == 6) check("held_press_E6", press[0], 1);
    end
    key[0] = 1'b1;
    repeat (12) tick();
    check("held_one_pulse", pc0 - base, 1);

    // Out-of-range select on a 3-key build
    sel3 = 2'd3;
    tick();
    check("sel_oob_leds", leds3, 0);
    sel3 = 2'd0;
    tick();
    check("sel3_cnt0", leds3, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/m1_keycnt.md
Name: m1_keycnt

Overview:
- Parametrised successor to the single-key press counter.
- Counts debounced presses on NKEYS independent active-low keys, each into its own WIDTH-bit counter.
- Selectable wrap or saturate arithmetic; per-channel overflow flags and press pulses; synchronous clear.
- The selected counter drives the board LEDs.
- All key inputs are synchronised into the single clock domain; there is no asynchronous edge clocking.

Parameters:
- WIDTH, 8: counter and LED width, ≥1.
- NKEYS, 2: number of key channels, ≥1.
- DEBOUNCE, 4: consecutive mismatching cycles required before the filtered key level changes, ≥1.
- SATURATE, 0: 0 = counter wraps max→0; 1 = counter holds at 2^WIDTH-1.
- SELW, max(1,clog2(NKEYS)): width of sel.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset (one clock; reset is asynchronous and active-high).
- key  in  NKEYS  raw asynchronous keys, active-low (0 = pressed).
- clr  in  1  synchronous clear of all counters and ovf flags.
- sel  in  SELW  channel shown on leds.
- leds  out  WIDTH  registered copy of cnt[sel].
- press  out  NKEYS  one-cycle pulse per accepted press.
- ovf  out  NKEYS  sticky flag: channel wrapped or hit saturation.

Behaviour:
- Reset (async assert, sync-released use) sets:
  - sync stages = 1, filtered level db = 1, debounce count = 0;
  - all counters = 0; leds = 0; press = 0; ovf = 0.
- Synchroniser: two flops per key (s1, s2), reset to 1.
- Debounce, per channel, evaluated each edge:
  - s2 == db → dcnt <= 0.
  - s2 != db and dcnt < DEBOUNCE-1 → dcnt <= dcnt+1.
  - s2 != db and dcnt == DEBOUNCE-1 → db <= s2, dcnt <= 0.
  - Any glitch shorter than DEBOUNCE cycles is ignored. A single-cycle return to db restarts the count.
- Press detect: press[i] <= db_prev & ~db, i.e. 1→0 transitions only. Releases produce nothing.
- Latency: key low set up before edge E0 gives:
  - s2 = 0 after E1;
  - db falls at E(1+DEBOUNCE);
  - press[i] high and counter updated at E(2+DEBOUNCE);
  - leds updated at E(3+DEBOUNCE). DEBOUNCE=4: press at E6, leds at E7.
- Counter update on press[i]:
  - Not at max → +1.
  - At max, SATURATE=0 → 0, and ovf[i] <= 1.
  - At max, SATURATE=1 → hold, and ovf[i] <= 1.
- clr:
  - All counters and ovf <= 0 at that edge.
  - clr wins over a same-cycle counter update; the press pulse is still emitted.
  - Debounce state is unaffected.
- Simultaneous presses on different channels: all counted in the same cycle, independently.
- leds <= cnt[sel] each edge, one cycle behind the counter. sel ≥ NKEYS → leds <= 0. A sel change takes effect on the next edge.
- Reset mid-debounce: partial debounce count discarded.
- Key held low through reset release: counted once, at E(2+DEBOUNCE) after the first edge following release. This is intended.
- No combinational path from any input to any output.

Decomposition:
- Package m1_pkg:
  - clog2 constant function;
  - key level constants KEY_UP=1, KEY_DOWN=0;
  - reset values for counter and leds.
- Sub-module m1_debounce (params DEBOUNCE):
  - inputs clk, rst, key_raw; output press pulse;
  - contains synchroniser, dcnt, db and edge detect;
  - instantiated NKEYS times via generate.
- Counters, ovf, clr and the leds mux live in m1_keycnt.

Test Plan:
All cases use WIDTH=8, NKEYS=2, DEBOUNCE=4, SATURATE=0 unless stated.
- Reset: assert rst with keys random → leds=0, press=0, ovf=0 immediately, with no clk edge needed.
- Clean press: key[0] low 10 cycles then high, sel=0 → press[0] single pulse at E6; leds=1 at E7; release produces no pulse.
- Bounce: key[1] toggles low 3 cycles / high 1 cycle ×5, then stays low → exactly one press[1], cnt[1]=1. A low pulse of 3 cycles alone → no press.
- Wrap: 256 presses on key[0] → cnt[0]=0, ovf[0]=1. Rerun with SATURATE=1 → cnt[0]=255, ovf[0]=1, and a 257th press leaves 255.
- Simultaneous and clear:
  - key[0] and key[1] pressed in the same cycle → both counters +1, checked via sel=0 then sel=1.
  - clr asserted in the cycle press[0] pulses → cnt[0]=0, ovf=0, press[0] still seen.
- Held through reset: key[0] low, pulse rst for 3 cycles → exactly one press[0] at E6 after release; sel=3 (NKEYS=3 build) → leds=0.
